// File: rtl/trace_request_queue.sv
// rtl/trace_request_queue.sv - timestamp-gated request FIFO between trace parser and scheduler
// Optional TRQ_STATS_EN adds max_count / stall_cycles statistics outputs.

package trace_request_queue_pkg;
  typedef enum logic [1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IFETCH = 2'd2,
    NOP    = 2'd3
  } parsed_op_t;
endpackage

module trace_request_queue
  import trace_request_queue_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = 33,
  parameter int TIME_WIDTH    = 64,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TIME_WIDTH-1:0]    in_time,
  input  parsed_op_t               in_op,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output parsed_op_t               out_op,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [TIME_WIDTH-1:0]    out_time,
  output logic [TIME_WIDTH-1:0]    cycle,
  output logic [CW-1:0]            count,
  output logic                     order_err
`ifdef TRQ_STATS_EN
  ,
  output logic [CW-1:0]            max_count,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    parsed_op_t                 op;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [TIME_WIDTH-1:0]      ts;
  } entry_t;

  entry_t                mem [DEPTH];
  entry_t                head;
  entry_t                held;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [TIME_WIDTH-1:0] last_time;
  logic [CW-1:0]         count_next;
  logic                  push;
  logic                  store;
  logic                  pop;
  logic                  not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign store     = push && (in_op != NOP);
  assign out_valid = not_empty && (mem[rd_ptr].ts <= cycle);
  assign pop       = out_valid && out_ready;

  // Outputs track the live head; once empty they show the last head seen.
  assign head        = not_empty ? mem[rd_ptr] : held;
  assign out_op      = head.op;
  assign out_address = head.address;
  assign out_time    = head.ts;

  always_comb begin
    count_next = count;
    unique case ({store, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= '{op: in_op, address: in_address, ts: in_time};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle     <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_time <= '0;
      order_err <= 1'b0;
      held      <= '{op: NOP, address: '0, ts: '0};
    end else begin
      cycle     <= (cycle == '1) ? cycle : cycle + 1'b1;
      count     <= count_next;
      order_err <= store && (in_time < last_time);
      if (store) begin
        wr_ptr    <= wr_ptr + 1'b1;
        last_time <= in_time;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (not_empty) begin
        held <= mem[rd_ptr];
      end
    end
  end

`ifdef TRQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (count_next > max_count) begin
        max_count <= count_next;
      end
      if (in_valid && !in_ready && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule
